// File: rtl/mode_ctrl.sv
// mode_ctrl: piano mode sequencer; turns button presses into mode/song selection
// and hands an active player a stop request (acknowledged or timed out) before switching.
module mode_ctrl #(
    parameter int NUM_SONGS   = 4,
    parameter int TO_W        = 16,
    parameter int ACK_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_confirm,
    input  logic       player_busy,
    input  logic       stop_ack,
    output logic [2:0] mode,
    output logic [1:0] song_num,
    output logic       start,
    output logic       stop_req,
    output logic       switching,
    output logic       timeout_err
);
    typedef enum logic [1:0] {RUN, STOP_WAIT, SWITCH} state_t;

    localparam logic [1:0]      LAST    = 2'(NUM_SONGS - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [1:0]      song_q, song_d;
    logic            start_q, start_d;
    logic            stop_q, stop_d;
    logic            to_q, to_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [3:0]      btn_q, btn_d, press;

    // bit order: mode, next, prev, confirm
    assign btn_d = {btn_mode, btn_next, btn_prev, btn_confirm};
    assign press = btn_d & ~btn_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        song_d  = song_q;
        start_d = 1'b0;
        stop_d  = stop_q;
        to_d    = 1'b0;
        timer_d = timer_q;
        case (state_q)
            RUN: begin
                if (press[3]) begin
                    stop_d  = player_busy;
                    timer_d = '0;
                    state_d = player_busy ? STOP_WAIT : SWITCH;
                end else if (mode_q[1] && !player_busy) begin
                    // mode_q[1] is set only in auto (011) and learning (111)
                    if (press[2] && !press[1])
                        song_d = (song_q == LAST) ? 2'd0 : song_q + 2'd1;
                    else if (press[1] && !press[2])
                        song_d = (song_q == 2'd0) ? LAST : song_q - 2'd1;
                    start_d = press[0];
                end
            end
            STOP_WAIT: begin
                if (stop_ack || timer_q == TO_LAST) begin
                    stop_d  = 1'b0;
                    to_d    = !stop_ack;
                    state_d = SWITCH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SWITCH: begin
                mode_d  = (mode_q == 3'b111) ? 3'b000 : {mode_q[1:0], 1'b1};
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            mode_q  <= 3'b000;
            song_q  <= 2'd0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            to_q    <= 1'b0;
            timer_q <= '0;
            btn_q   <= 4'b1111;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            song_q  <= song_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            to_q    <= to_d;
            timer_q <= timer_d;
            btn_q   <= btn_d;
        end
    end

    assign mode        = mode_q;
    assign song_num    = song_q;
    assign start       = start_q;
    assign stop_req    = stop_q;
    assign switching   = (state_q != RUN);
    assign timeout_err = to_q;
endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Top-level mode sequencer for the piano.
- Turns debounced front-panel buttons into the mode code (000 hello, 001 free/manual, 011 auto, 111 learning) and the 2-bit song number consumed by the output signal selector.
- Sequences mode changes safely: an active player (auto or learning) is asked to stop, and its acknowledge is awaited (with timeout) before the mode switches.
- Issues a one-cycle start pulse to the auto/learning players.

Parameters:
- NUM_SONGS, 4, number of selectable songs (1..4); song_num wraps within 0..NUM_SONGS-1.
- TO_W, 16, width of the stop-acknowledge timeout counter.
- ACK_TIMEOUT, 50000, cycles to wait for stop_ack before a forced switch; must be >=1 and <2^TO_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_mode  input  1  debounced, synchronous level; a rising edge requests the next mode.
- btn_next  input  1  debounced level; a rising edge selects the next song.
- btn_prev  input  1  debounced level; a rising edge selects the previous song.
- btn_confirm  input  1  debounced level; a rising edge starts the selected song.
- player_busy  input  1  the active auto/learning player is playing.
- stop_ack  input  1  the player has stopped in response to stop_req.
- mode  output  3  current mode code: 000, 001, 011 or 111.
- song_num  output  2  selected song index.
- start  output  1  one-cycle start pulse.
- stop_req  output  1  level; asks the player to stop.
- switching  output  1  high while a mode change is pending (state != RUN).
- timeout_err  output  1  one-cycle pulse when a switch is forced by timeout.

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous, active-low (rst_n). It acts immediately, including mid-operation.
- Reset values: mode=000, song_num=0, start=0, stop_req=0, switching=0, timeout_err=0, state=RUN, timer=0.
- The edge-detect flops for all four buttons reset to 1. A button already held when reset releases produces no event until it is released and pressed again.
- Press detection: press_x = btn_x & ~btn_x_q, evaluated every cycle.
- Mode sequence: 000 -> 001 -> 011 -> 111 -> 000. mode only ever holds these four values.
- FSM states: RUN, STOP_WAIT, SWITCH.
- RUN, mode press with player_busy=1: stop_req<=1, timer<=0, go to STOP_WAIT.
- RUN, mode press with player_busy=0: go to SWITCH.
- STOP_WAIT, stop_ack=1: stop_req<=0, go to SWITCH.
- STOP_WAIT, no ack and timer==ACK_TIMEOUT-1: stop_req<=0, timeout_err<=1 for one cycle, go to SWITCH.
- STOP_WAIT otherwise: timer increments.
- STOP_WAIT, ack and timeout in the same cycle: ack wins and no timeout_err pulse is produced.
- SWITCH: mode<=next mode, go to RUN. This state lasts exactly one cycle. song_num is retained across mode changes.
- Latency for an idle mode change: press sampled at edge E0, state=SWITCH after E0, new mode visible after E1. switching is high for exactly one cycle.
- Song select (RUN only, mode 011 or 111, player_busy=0):
  - next: song_num+1, wrapping NUM_SONGS-1 -> 0.
  - prev: song_num-1, wrapping 0 -> NUM_SONGS-1.
  - Update is registered at the same edge that samples the press.
- next and prev pressed in the same cycle: both are ignored.
- Confirm (RUN only, mode 011 or 111, player_busy=0): start=1 for the cycle after the sampling edge, then 0. Confirm in mode 000 or 001, or while busy, is ignored.
- Priority within one RUN cycle: a mode press wins; next/prev/confirm in that same cycle are dropped.
- Presses during STOP_WAIT or SWITCH are dropped, not queued.
- start and timeout_err are never high for more than one consecutive cycle.

Test Plan:
- Reset then 4 idle btn_mode presses (busy=0): mode steps 001, 011, 111, 000. Each change appears 2 edges after the press; switching is high for 1 cycle per press.
- mode=011, NUM_SONGS=4: prev from 0 -> 3, then next x2 -> 0 then 1. Then next+prev in the same cycle -> stays 1. In mode 001, next leaves song_num unchanged.
- mode=011, confirm with busy=0 -> start high exactly 1 cycle. Confirm with busy=1 -> no start. Confirm and mode pressed together -> mode path taken, no start.
- mode=011, busy=1, press mode -> stop_req=1. stop_ack after 5 cycles -> stop_req drops, mode=111 on the following cycle, no timeout_err.
- ACK_TIMEOUT=8, busy=1, no ack, press mode -> stop_req high 8 cycles, timeout_err pulses once, mode advances. A btn_next press during the wait is dropped.
- Hold btn_mode through reset release -> no mode change. Assert rst_n=0 during STOP_WAIT -> stop_req, mode and switching clear immediately.
